// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage plus the IF/ID register feeding decode/control.
//   Keeps the PC, fetches 32-bit words over a req/ack + rvalid handshake
//   (at most one request outstanding), and redirects the PC on branch/jump
//   decisions returned by control. There are no delay slots: any fetch that
//   is already in flight when a redirect happens is squashed.
//
//   Ports
//     clk, rst                  clock (rising edge), synchronous active-high reset
//     imem_req / imem_addr      fetch request and its address (always = pc)
//     imem_ack                  request accepted this cycle
//     imem_rvalid / imem_rdata  returned instruction word
//     id_valid / id_ready       IF/ID occupancy and decode consume strobe
//     id_pc / id_inst           IF/ID contents
//     ct_inst / aluct_inst      opcode / funct slices of id_inst for control
//     ct_branch, ct_jump        control decode of the IF/ID instruction
//     br_taken                  branch condition (ALU zero)
//     fetch_err                 sticky flag: imem response timed out
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | one dead cycle after reset, no request
//   REQ   | imem_req high, waiting for imem_ack
//   WAIT  | request accepted, waiting for imem_rvalid
//   HOLD  | word returned while IF/ID was full; parked in skid register
//   ERR   | response timeout; fetching stopped until reset
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [5:0]  ct_inst,
    output logic [5:0]  aluct_inst,
    input  logic        ct_branch,
    input  logic        ct_jump,
    input  logic        br_taken,
    output logic        fetch_err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // Down-counter start value so that the timeout fires at the end of the
    // WAIT_LIMIT-th cycle spent in WAIT.
    localparam logic [31:0] WAIT_LOAD = (WAIT_LIMIT == 0) ? 32'd0 : WAIT_LIMIT - 32'd1;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic [31:0] skid_inst;
    logic        drop;
    logic [31:0] wait_cnt;

    logic        consume;
    logic        redirect;
    logic [31:0] pc_p4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic        accept;
    logic        in_wait;
    logic        word_ok;
    logic        load_new;
    logic        to_skid;
    logic        load_skid;
    logic        timeout;

    assign consume   = id_valid & id_ready;
    assign redirect  = consume & (ct_jump | (ct_branch & br_taken));

    assign pc_p4     = id_pc + 32'd4;
    assign br_target = pc_p4 + {{14{id_inst[15]}}, id_inst[15:0], 2'b00};
    assign j_target  = {pc_p4[31:28], id_inst[25:0], 2'b00};
    assign target    = ct_jump ? j_target : br_target;

    assign accept    = (state == ST_REQ) & imem_ack;
    assign in_wait   = (state == ST_WAIT);

    // A returned word is usable only if it belongs to the current path:
    // not marked for dropping and not overtaken by a redirect this cycle.
    assign word_ok   = in_wait & imem_rvalid & ~drop & ~redirect;
    assign load_new  = word_ok & (~id_valid | consume);
    assign to_skid   = word_ok & id_valid & ~consume;
    assign load_skid = (state == ST_HOLD) & consume & ~redirect;

    assign timeout   = (WAIT_LIMIT != 0) & in_wait & ~imem_rvalid & (wait_cnt == 32'd0);

    assign imem_req   = (state == ST_REQ);
    assign imem_addr  = pc;
    assign ct_inst    = id_inst[31:26];
    assign aluct_inst = id_inst[5:0];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ: begin
                if (accept) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (drop | redirect | load_new) state_nxt = ST_REQ;
                    else                            state_nxt = ST_HOLD;
                end else if (timeout) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_HOLD: begin
                // Either the skid word moves into IF/ID or a redirect kills it.
                if (consume) state_nxt = ST_REQ;
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            fetch_pc  <= 32'd0;
            skid_inst <= 32'd0;
            drop      <= 1'b0;
            wait_cnt  <= 32'd0;
            fetch_err <= 1'b0;
            id_valid  <= 1'b0;
            id_inst   <= 32'd0;
            id_pc     <= 32'd0;
        end else begin
            state <= state_nxt;

            if (redirect)    pc <= target;
            else if (accept) pc <= pc + 32'd4;

            if (accept) begin
                fetch_pc <= pc;
                wait_cnt <= WAIT_LOAD;
            end else if (in_wait & ~imem_rvalid & (wait_cnt != 32'd0)) begin
                wait_cnt <= wait_cnt - 32'd1;
            end

            // The outstanding response (if any) is wrong-path once a redirect
            // happens with or after its accept; clear the mark when it lands.
            if (in_wait & imem_rvalid)                drop <= 1'b0;
            else if (redirect & (accept | in_wait))   drop <= 1'b1;

            if (to_skid) skid_inst <= imem_rdata;

            if (timeout) fetch_err <= 1'b1;

            // skid words always belong to fetch_pc: no new accept can happen
            // until HOLD has been left.
            if (redirect) begin
                id_valid <= 1'b0;
                id_inst  <= 32'd0;
            end else if (load_new) begin
                id_valid <= 1'b1;
                id_inst  <= imem_rdata;
                id_pc    <= fetch_pc;
            end else if (load_skid) begin
                id_valid <= 1'b1;
                id_inst  <= skid_inst;
                id_pc    <= fetch_pc;
            end else if (consume) begin
                id_valid <= 1'b0;
                id_inst  <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [5:0]  ct_inst;
    logic [5:0]  aluct_inst;
    logic        ct_branch;
    logic        ct_jump;
    logic        br_taken;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    // memory responder state
    logic        pend;
    logic [31:0] paddr;
    logic        mem_hold;
    logic [31:0] mem [logic [31:0]];

    inst_fetch #(
        .RESET_PC   (32'h0000_3000),
        .WAIT_LIMIT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .ct_inst     (ct_inst),
        .aluct_inst  (aluct_inst),
        .ct_branch   (ct_branch),
        .ct_jump     (ct_jump),
        .br_taken    (br_taken),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {12'h001, a[19:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: note an accept before the edge, then after the edge return
    // the word (1-cycle latency) and decode the new IF/ID contents.
    task automatic tick();
        @(negedge clk);
        if (imem_req && imem_ack) begin
            pend  = 1'b1;
            paddr = imem_addr;
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (pend && !mem_hold) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
            pend        = 1'b0;
        end
        ct_jump   = id_valid && (id_inst[31:26] == 6'h02);
        ct_branch = id_valid && (id_inst[31:26] == 6'h04);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        pend        = 1'b0;
        imem_rvalid = 1'b0;
        rst         = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        br;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic set_vec(input int i, input logic rdy, input logic br, input logic req,
                           input logic [31:0] addr, input logic valid,
                           input logic [31:0] pc, input logic [31:0] inst);
        vecs[i].rdy   = rdy;
        vecs[i].br    = br;
        vecs[i].req   = req;
        vecs[i].addr  = addr;
        vecs[i].valid = valid;
        vecs[i].pc    = pc;
        vecs[i].inst  = inst;
    endtask

    initial begin
        logic [31:0] e;
        rst = 1'b1; imem_ack = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        id_ready = 1'b0; ct_branch = 1'b0; ct_jump = 1'b0; br_taken = 1'b0;
        pend = 1'b0; paddr = 32'd0; mem_hold = 1'b0;
        mem[32'h3000] = 32'h8C22_0004;   // lw
        mem[32'h3010] = 32'h1000_FFFF;   // beq, imm = -1

        //        row rdy br req addr          valid pc            inst
        set_vec(0,  1, 0, 1, 32'h3000, 0, 32'h0,    32'h0);
        set_vec(1,  1, 0, 0, 32'h3004, 0, 32'h0,    32'h0);
        set_vec(2,  1, 0, 1, 32'h3004, 1, 32'h3000, 32'h8C22_0004);
        set_vec(3,  1, 0, 0, 32'h3008, 0, 32'h0,    32'h0);
        set_vec(4,  1, 0, 1, 32'h3008, 1, 32'h3004, mem_word(32'h3004));
        set_vec(5,  1, 0, 0, 32'h300C, 0, 32'h0,    32'h0);
        // stall decode: next word parks in the skid register
        set_vec(6,  0, 0, 1, 32'h300C, 1, 32'h3008, mem_word(32'h3008));
        set_vec(7,  0, 0, 0, 32'h3010, 1, 32'h3008, mem_word(32'h3008));
        set_vec(8,  0, 0, 0, 32'h3010, 1, 32'h3008, mem_word(32'h3008));
        set_vec(9,  1, 0, 0, 32'h3010, 1, 32'h3008, mem_word(32'h3008));
        set_vec(10, 0, 0, 1, 32'h3010, 1, 32'h300C, mem_word(32'h300C));
        set_vec(11, 1, 0, 0, 32'h3014, 1, 32'h300C, mem_word(32'h300C));
        // taken beq back to itself while the 0x3014 word is in flight
        set_vec(12, 0, 1, 1, 32'h3014, 1, 32'h3010, 32'h1000_FFFF);
        set_vec(13, 1, 1, 0, 32'h3018, 1, 32'h3010, 32'h1000_FFFF);
        set_vec(14, 1, 1, 1, 32'h3010, 0, 32'h0,    32'h0);
        set_vec(15, 1, 1, 0, 32'h3014, 0, 32'h0,    32'h0);
        // same beq, not taken: falls through to 0x3014
        set_vec(16, 1, 0, 1, 32'h3014, 1, 32'h3010, 32'h1000_FFFF);
        set_vec(17, 1, 0, 0, 32'h3018, 0, 32'h0,    32'h0);
        set_vec(18, 1, 0, 1, 32'h3018, 1, 32'h3014, mem_word(32'h3014));

        // reset state
        id_ready = 1'b1;
        do_reset();
        check("reset id_valid",  32'(id_valid),  32'd0);
        check("reset imem_req",  32'(imem_req),  32'd0);
        check("reset fetch_err", 32'(fetch_err), 32'd0);
        check("reset id_inst",   id_inst,        32'd0);
        check("reset id_pc",     id_pc,          32'd0);
        check("reset ct_inst",   32'(ct_inst),   32'd0);
        tick();

        for (int i = 0; i < NV; i++) begin
            id_ready = vecs[i].rdy;
            br_taken = vecs[i].br;
            e = vecs[i].inst;
            check($sformatf("row%0d imem_req", i),   32'(imem_req),   32'(vecs[i].req));
            check($sformatf("row%0d imem_addr", i),  imem_addr,       vecs[i].addr);
            check($sformatf("row%0d id_valid", i),   32'(id_valid),   32'(vecs[i].valid));
            check($sformatf("row%0d id_inst", i),    id_inst,         e);
            check($sformatf("row%0d ct_inst", i),    32'(ct_inst),    32'(e[31:26]));
            check($sformatf("row%0d aluct_inst", i), 32'(aluct_inst), 32'(e[5:0]));
            if (vecs[i].valid)
                check($sformatf("row%0d id_pc", i), id_pc, vecs[i].pc);
            tick();
        end

        // jump at 0x3000, redirect coinciding with the accept of 0x3004
        mem[32'h3000] = 32'h0800_0C10;
        id_ready = 1'b1;
        br_taken = 1'b0;
        do_reset();
        tick();
        check("j first req", imem_addr, 32'h3000);
        tick();
        tick();
        check("j id_valid",  32'(id_valid), 32'd1);
        check("j id_pc",     id_pc,         32'h3000);
        check("j ct_inst",   32'(ct_inst),  32'h02);
        check("j req 3004",  imem_addr,     32'h3004);
        tick();
        check("j redirect imem_req", 32'(imem_req), 32'd0);
        check("j redirect id_valid", 32'(id_valid), 32'd0);
        check("j target",            imem_addr,     32'h0000_3040);
        tick();
        check("j dropped imem_req",  32'(imem_req), 32'd1);
        check("j dropped id_valid",  32'(id_valid), 32'd0);
        check("j req target",        imem_addr,     32'h0000_3040);
        tick();
        tick();
        check("j target id_valid",   32'(id_valid), 32'd1);
        check("j target id_pc",      id_pc,         32'h0000_3040);
        check("j target id_inst",    id_inst,       mem_word(32'h3040));

        // response timeout
        mem_hold = 1'b1;
        do_reset();
        tick();
        check("to imem_req", 32'(imem_req), 32'd1);
        tick();
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("to wait%0d fetch_err", k), 32'(fetch_err), 32'd0);
            tick();
        end
        check("to wait8 fetch_err", 32'(fetch_err), 32'd0);
        check("to wait8 imem_req",  32'(imem_req),  32'd0);
        tick();
        check("to err fetch_err", 32'(fetch_err), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("to err%0d imem_req", k),  32'(imem_req),  32'd0);
            check($sformatf("to err%0d fetch_err", k), 32'(fetch_err), 32'd1);
        end
        mem_hold = 1'b0;
        do_reset();
        check("to rst fetch_err", 32'(fetch_err), 32'd0);
        tick();
        check("to rst imem_req",  32'(imem_req),  32'd1);
        check("to rst imem_addr", imem_addr,      32'h3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
